// File: rtl/exc_ctrl.sv
// Exception/interrupt commit unit: prioritises MEM-stage faults and interrupts, issues one CP0 write, flushes and redirects fetch.
// Optional build macro EXC_CTRL_CNT_EN adds the exc_count output (committed exception/interrupt counter).
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_stall,
    input  logic [31:0] ex_pc,
    input  logic        ex_bd,
    input  logic        ex_adel_if,
    input  logic        ex_ri,
    input  logic        ex_ov,
    input  logic        ex_sys,
    input  logic        ex_bp,
    input  logic        ex_adel_ld,
    input  logic        ex_ades,
    input  logic [31:0] ex_badaddr,
    input  logic        ex_eret,
    input  logic [7:0]  intr_vect,
    input  logic [31:0] er_epc,
    output logic        cp0w_we,
    output logic        cp0w_bd,
    output logic        cp0w_exl,
    output logic [4:0]  cp0w_exc,
    output logic [31:0] cp0w_epc,
    output logic [31:0] cp0w_bva,
    output logic        flush,
    output logic        redir_valid,
    output logic [31:0] redir_pc
`ifdef EXC_CTRL_CNT_EN
    ,
    output logic [31:0] exc_count
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        bd_q, bd_d;
    logic        exl_q, exl_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bva_q, bva_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;
    logic        sh_bd_q, sh_bd_d;
    logic [4:0]  sh_exc_q, sh_exc_d;
    logic [31:0] sh_bva_q, sh_bva_d;

    logic        is_exc;
    logic [4:0]  code;
    logic [31:0] bva_new;
    logic        commit_exc;

    // Fault priority encoder; codes without an address keep the shadowed BadVAddr.
    always_comb begin
        is_exc  = 1'b1;
        code    = 5'd0;
        bva_new = sh_bva_q;
        if (intr_vect != 8'h00) begin
            code = 5'd0;
        end else if (ex_adel_if) begin
            code    = 5'd4;
            bva_new = ex_pc;
        end else if (ex_ri) begin
            code = 5'd10;
        end else if (ex_ov) begin
            code = 5'd12;
        end else if (ex_sys) begin
            code = 5'd8;
        end else if (ex_bp) begin
            code = 5'd9;
        end else if (ex_adel_ld) begin
            code    = 5'd4;
            bva_new = ex_badaddr;
        end else if (ex_ades) begin
            code    = 5'd5;
            bva_new = ex_badaddr;
        end else begin
            is_exc = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        rv_d       = 1'b0;
        bd_d       = bd_q;
        exl_d      = exl_q;
        exc_d      = exc_q;
        epc_d      = epc_q;
        bva_d      = bva_q;
        flush_d    = flush_q;
        rpc_d      = rpc_q;
        sh_bd_d    = sh_bd_q;
        sh_exc_d   = sh_exc_q;
        sh_bva_d   = sh_bva_q;
        commit_exc = 1'b0;
        case (state_q)
            IDLE: begin
                flush_d = 1'b0;
                if (ex_valid && !mem_stall && (is_exc || ex_eret)) begin
                    we_d    = 1'b1;
                    rv_d    = 1'b1;
                    flush_d = 1'b1;
                    cnt_d   = 4'(FLUSH_CYCLES - 1);
                    state_d = FLUSH;
                    if (is_exc) begin
                        commit_exc = 1'b1;
                        exl_d      = 1'b1;
                        bd_d       = ex_bd;
                        exc_d      = code;
                        bva_d      = bva_new;
                        epc_d      = ex_bd ? ex_pc - 32'd4 : ex_pc;
                        rpc_d      = EXC_VECTOR;
                        sh_bd_d    = ex_bd;
                        sh_exc_d   = code;
                        sh_bva_d   = bva_new;
                    end else begin
                        exl_d = 1'b0;
                        bd_d  = sh_bd_q;
                        exc_d = sh_exc_q;
                        bva_d = sh_bva_q;
                        epc_d = er_epc;
                        rpc_d = er_epc;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            bd_q     <= 1'b0;
            exl_q    <= 1'b0;
            exc_q    <= '0;
            epc_q    <= '0;
            bva_q    <= '0;
            flush_q  <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            sh_bd_q  <= 1'b0;
            sh_exc_q <= '0;
            sh_bva_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            bd_q     <= bd_d;
            exl_q    <= exl_d;
            exc_q    <= exc_d;
            epc_q    <= epc_d;
            bva_q    <= bva_d;
            flush_q  <= flush_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            sh_bd_q  <= sh_bd_d;
            sh_exc_q <= sh_exc_d;
            sh_bva_q <= sh_bva_d;
        end
    end

    assign cp0w_we     = we_q;
    assign cp0w_bd     = bd_q;
    assign cp0w_exl    = exl_q;
    assign cp0w_exc    = exc_q;
    assign cp0w_epc    = epc_q;
    assign cp0w_bva    = bva_q;
    assign flush       = flush_q;
    assign redir_valid = rv_q;
    assign redir_pc    = rpc_q;

`ifdef EXC_CTRL_CNT_EN
    logic [31:0] cnt_exc_q, cnt_exc_d;

    always_comb begin
        cnt_exc_d = commit_exc ? cnt_exc_q + 32'd1 : cnt_exc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_exc_q <= '0;
        else      cnt_exc_q <= cnt_exc_d;
    end

    assign exc_count = cnt_exc_q;
`else
    logic unused_commit;
    assign unused_commit = commit_exc;
`endif

endmodule
